// File: rtl/inv_mix_columns.sv
// ============================================================================
// Module      : inv_mix_columns
// Description : AES InvMixColumns stage, one column per cycle through a shared
//               GF(2^8) column datapath, with final-round bypass.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inv_mix_columns (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         bypass,
    output logic [127:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        COL0 = 3'd1,
        COL1 = 3'd2,
        COL2 = 3'd3,
        COL3 = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_buf;
    logic           r_bypass;
    logic [127:0]   r_result;
    logic           w_accept;
    logic           w_col_en;
    logic [1:0]     w_col_idx;
    logic [31:0]    w_col_in;
    logic [31:0]    w_col_out;

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse mix of one column; all four coefficients share the x2/x4/x8 chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a    [4];
        logic [7:0] m09  [4];
        logic [7:0] m0b  [4];
        logic [7:0] m0d  [4];
        logic [7:0] m0e  [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]   = col[31-8*r -: 8];
            x2     = xtime(a[r]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m09[r] = x8 ^ a[r];
            m0b[r] = x8 ^ x2 ^ a[r];
            m0d[r] = x8 ^ x4 ^ a[r];
            m0e[r] = x8 ^ x4 ^ x2;
        end
        return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
                m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
                m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
                m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
    endfunction

    assign din_ready  = (r_state == IDLE);
    assign dout_valid = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign dout       = r_result;
    assign w_accept   = din_valid & din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_col_en  = 1'b0;
        w_col_idx = 2'd0;
        case (r_state)
            IDLE: if (w_accept) w_next = bypass ? DONE : COL0;
            COL0: begin w_col_en = 1'b1; w_col_idx = 2'd0; w_next = COL1; end
            COL1: begin w_col_en = 1'b1; w_col_idx = 2'd1; w_next = COL2; end
            COL2: begin w_col_en = 1'b1; w_col_idx = 2'd2; w_next = COL3; end
            COL3: begin w_col_en = 1'b1; w_col_idx = 2'd3; w_next = DONE; end
            DONE: if (dout_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        case (w_col_idx)
            2'd0:    w_col_in = r_buf[127:96];
            2'd1:    w_col_in = r_buf[95:64];
            2'd2:    w_col_in = r_buf[63:32];
            default: w_col_in = r_buf[31:0];
        endcase
    end

    assign w_col_out = inv_mix_col(w_col_in);

    // Buffer and flag load only on accept, so later din/bypass activity is inert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf    <= '0;
            r_bypass <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_buf    <= din;
            r_bypass <= bypass;
            if (bypass) r_result <= din;
        end else if (w_col_en) begin
            case (w_col_idx)
                2'd0:    r_result[127:96] <= w_col_out;
                2'd1:    r_result[95:64]  <= w_col_out;
                2'd2:    r_result[63:32]  <= w_col_out;
                default: r_result[31:0]   <= w_col_out;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/inv_mix_columns.md
INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 din  input  128  round state from the upstream AddRoundKey stage; column c = din[127-32c -: 32], byte r of a column = bits [31-8r -: 8] within it.
REQ-005 din_valid  input  1  din and bypass are valid this cycle.
REQ-006 din_ready  output  1  block can accept a state this cycle.
REQ-007 bypass  input  1  sampled with din; 1 = final-round pass-through, no InvMixColumns.
REQ-008 dout  output  128  transformed state, same byte ordering as din, feeding the downstream inv_shift_rows / inv_sub_bytes path.
REQ-009 dout_valid  output  1  dout holds a completed result.
REQ-010 dout_ready  input  1  downstream accepts dout this cycle.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, COL0, COL1, COL2, COL3 and DONE.
REQ-013 din_ready SHALL be 1 only in IDLE.
REQ-014 Accept = din_valid & din_ready; on accept, din SHALL be latched into an input buffer and bypass into a flag.
REQ-015 On accept with bypass=0: IDLE->COL0; with bypass=1: IDLE->DONE and result register := din.
REQ-016 In COLc (c=0..3), result column c := InvMixColumns(buffer column c); COL0->COL1->COL2->COL3->DONE unconditionally, one column per cycle.
REQ-017 InvMixColumns per column (a0..a3 -> b0..b3): b0=0e*a0^0b*a1^0d*a2^09*a3; b1=09*a0^0e*a1^0b*a2^0d*a3; b2=0d*a0^09*a1^0e*a2^0b*a3; b3=0b*a0^0d*a1^09*a2^0e*a3.
REQ-018 GF(2^8) multiplication SHALL use reduction polynomial 0x11B; all results 8 bits, no overflow.
REQ-019 Only one column multiplier datapath SHALL be instantiated, shared across COL0..COL3.
REQ-020 dout SHALL be driven directly from the result register; dout_valid SHALL be 1 only in DONE.
REQ-021 Latency: bypass=0 -> dout_valid high after the 5th rising edge, counting the accept edge as the 1st; bypass=1 -> high after the accept edge.
REQ-022 In DONE with dout_ready=0, dout and dout_valid SHALL hold stable indefinitely.
REQ-023 In DONE with dout_ready=1, state SHALL return to IDLE at the next edge; din_ready rises in that next cycle (no same-cycle accept in DONE).
REQ-024 din_valid asserted outside IDLE SHALL be ignored and SHALL NOT disturb the buffer or the bypass flag.
REQ-025 Changes on din/bypass after accept SHALL NOT affect the in-flight result.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, dout=0, dout_valid=0, busy=0, din_ready=1 (once rst=0), buffer=0, bypass flag=0, independent of clk.
REQ-027 Reset asserted mid-operation (any COLc or DONE) SHALL discard the in-flight state with no output handshake.
REQ-028 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-029 Single column vector: din = {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}, bypass=0 -> dout = {db135345, f20a225c, 01010101, c6c6c6c6}, dout_valid after 5th edge.
REQ-030 Second vector: din = {d5d5d7d6, 4d7ebdf8, 00000000, ffffffff}, bypass=0 -> dout = {d4d4d4d5, 2d26314c, 00000000, ffffffff}.
REQ-031 Bypass: din = 00112233445566778899aabbccddeeff, bypass=1 -> identical dout, dout_valid after accept edge, busy high one cycle.
REQ-032 Backpressure: hold dout_ready=0 for 10 cycles in DONE while toggling din/din_valid -> dout stable, din_ready=0, result unchanged; then dout_ready=1 -> IDLE next cycle.
REQ-033 Reset in COL2: assert rst asynchronously -> dout=0, dout_valid=0, busy=0 without a clock edge; the next vector after release completes correctly.
REQ-034 Back-to-back: din_valid held high with two vectors -> second accepted only in IDLE after the first handshake; both results correct, in order.
